// File: rtl/zynq_shell_pkg.sv
// Shared constants for the Zynq AXI-Lite CSR/FIFO shell.
// Register offsets are word indices relative to the CSR count.
package zynq_shell_pkg;

    localparam int unsigned OFF_PS2PL_DATA  = 0;
    localparam int unsigned OFF_PS2PL_FREE  = 1;
    localparam int unsigned OFF_PL2PS_DATA  = 2;
    localparam int unsigned OFF_PL2PS_COUNT = 3;

    localparam logic [1:0] axil_resp_okay   = 2'b00;
    localparam logic [1:0] axil_resp_slverr = 2'b10;

    function automatic int count_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/zynq_shell_fifo.sv
// Single-clock 1r1w FIFO with a registered occupancy count.
// Push side is valid/ready, pop side is valid/yumi.
module zynq_shell_fifo
    import zynq_shell_pkg::*;
#(
    parameter int els_p   = 8,
    parameter int width_p = 32,
    localparam int CW = count_width(els_p),
    localparam int PW = $clog2(els_p)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [CW-1:0]      count_o
);

    logic [width_p-1:0] mem [els_p];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;

    assign ready_o = (count != CW'(els_p));
    assign v_o     = (count != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // Depth is a power of two, so pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zynq_axil_csr_fifo_shell.sv
// AXI4-Lite slave on PS GP port s00: control registers plus
// a PS->PL and a PL->PS FIFO, one outstanding access per channel.
module zynq_axil_csr_fifo_shell
    import zynq_shell_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32,
    parameter int num_regs_p   = 4,
    parameter int fifo_els_p   = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [addr_width_p-1:0]    s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [addr_width_p-1:0]    s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [num_regs_p*32-1:0]   csr_data_o,
    output logic [num_regs_p-1:0]      csr_w_o,
    output logic [31:0]                ps2pl_data_o,
    output logic                       ps2pl_v_o,
    input  logic                       ps2pl_yumi_i,
    input  logic [31:0]                pl2ps_data_i,
    input  logic                       pl2ps_v_i,
    output logic                       pl2ps_ready_o
);

    localparam int KW = addr_width_p - 2;
    localparam int CW = count_width(fifo_els_p);
    localparam logic [KW-1:0] K_NREGS       = KW'(num_regs_p);
    localparam logic [KW-1:0] K_PS2PL_DATA  = KW'(num_regs_p + OFF_PS2PL_DATA);
    localparam logic [KW-1:0] K_PS2PL_FREE  = KW'(num_regs_p + OFF_PS2PL_FREE);
    localparam logic [KW-1:0] K_PL2PS_DATA  = KW'(num_regs_p + OFF_PL2PS_DATA);
    localparam logic [KW-1:0] K_PL2PS_COUNT = KW'(num_regs_p + OFF_PL2PS_COUNT);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [31:0]           csr [num_regs_p];
    logic [KW-1:0]         wk, rk;
    logic                  aw_hs, ar_hs;
    logic [1:0]            w_resp, r_resp;
    logic [31:0]           r_data;
    logic [num_regs_p-1:0] csr_we;
    logic                  push_v, pop_v;
    logic                  ps2pl_ready;
    logic [CW-1:0]         ps2pl_count;
    logic [31:0]           pl2ps_head;
    logic                  pl2ps_v;
    logic [CW-1:0]         pl2ps_count;
    logic                  unused;

    assign unused = ^{s_axil_awprot, s_axil_arprot,
                      s_axil_awaddr[1:0], s_axil_araddr[1:0],
                      data_width_p};

    assign wk = s_axil_awaddr[addr_width_p-1:2];
    assign rk = s_axil_araddr[addr_width_p-1:2];

    assign s_axil_awready = aw_hs;
    assign s_axil_wready  = aw_hs;
    assign s_axil_bvalid  = (w_state == W_RESP);
    assign s_axil_arready = aresetn && (r_state == R_IDLE);
    assign s_axil_rvalid  = (r_state == R_DATA);

    for (genvar g = 0; g < num_regs_p; g++) begin : g_csr_out
        assign csr_data_o[32*g +: 32] = csr[g];
    end

    always_comb begin
        w_next = w_state;
        aw_hs  = 1'b0;
        unique case (w_state)
            W_IDLE: if (aresetn && s_axil_awvalid && s_axil_wvalid) begin
                aw_hs  = 1'b1;
                w_next = W_RESP;
            end
            W_RESP: if (s_axil_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        ar_hs  = 1'b0;
        unique case (r_state)
            R_IDLE: if (aresetn && s_axil_arvalid) begin
                ar_hs  = 1'b1;
                r_next = R_DATA;
            end
            R_DATA: if (s_axil_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Push only when the full word is written and the FIFO has room.
    always_comb begin
        w_resp = axil_resp_slverr;
        csr_we = '0;
        push_v = 1'b0;
        unique case (1'b1)
            (wk < K_NREGS): begin
                w_resp = axil_resp_okay;
                for (int i = 0; i < num_regs_p; i++)
                    if (wk == KW'(i)) csr_we[i] = 1'b1;
            end
            (wk == K_PS2PL_DATA): begin
                if (s_axil_wstrb == 4'hF && ps2pl_ready) begin
                    w_resp = axil_resp_okay;
                    push_v = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        r_resp = axil_resp_slverr;
        r_data = '0;
        pop_v  = 1'b0;
        unique case (1'b1)
            (rk < K_NREGS): begin
                r_resp = axil_resp_okay;
                for (int i = 0; i < num_regs_p; i++)
                    if (rk == KW'(i)) r_data = csr[i];
            end
            (rk == K_PS2PL_DATA): r_resp = axil_resp_okay;
            (rk == K_PS2PL_FREE): begin
                r_resp = axil_resp_okay;
                r_data = 32'(fifo_els_p) - 32'(ps2pl_count);
            end
            (rk == K_PL2PS_DATA): begin
                if (pl2ps_v) begin
                    r_resp = axil_resp_okay;
                    r_data = pl2ps_head;
                    pop_v  = 1'b1;
                end
            end
            (rk == K_PL2PS_COUNT): begin
                r_resp = axil_resp_okay;
                r_data = 32'(pl2ps_count);
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axil_bresp <= '0;
            s_axil_rresp <= '0;
            s_axil_rdata <= '0;
            csr_w_o      <= '0;
            for (int i = 0; i < num_regs_p; i++) csr[i] <= '0;
        end else begin
            csr_w_o <= aw_hs ? csr_we : '0;
            if (aw_hs) s_axil_bresp <= w_resp;
            if (ar_hs) begin
                s_axil_rresp <= r_resp;
                s_axil_rdata <= r_data;
            end
            for (int i = 0; i < num_regs_p; i++)
                for (int b = 0; b < 4; b++)
                    if (aw_hs && csr_we[i] && s_axil_wstrb[b])
                        csr[i][8*b +: 8] <= s_axil_wdata[8*b +: 8];
        end
    end

    zynq_shell_fifo #(.els_p(fifo_els_p), .width_p(32)) u_ps2pl (
        .clk     (aclk),
        .rst_n   (aresetn),
        .data_i  (s_axil_wdata),
        .v_i     (aw_hs & push_v),
        .ready_o (ps2pl_ready),
        .data_o  (ps2pl_data_o),
        .v_o     (ps2pl_v_o),
        .yumi_i  (ps2pl_yumi_i),
        .count_o (ps2pl_count)
    );

    zynq_shell_fifo #(.els_p(fifo_els_p), .width_p(32)) u_pl2ps (
        .clk     (aclk),
        .rst_n   (aresetn),
        .data_i  (pl2ps_data_i),
        .v_i     (pl2ps_v_i),
        .ready_o (pl2ps_ready_o),
        .data_o  (pl2ps_head),
        .v_o     (pl2ps_v),
        .yumi_i  (ar_hs & pop_v),
        .count_o (pl2ps_count)
    );

endmodule

// File: tb/tb_zynq_axil_csr_fifo_shell.sv
// Directed bench for the AXI-Lite CSR/FIFO shell.
// Expected values are hand-computed constants.
module tb_zynq_axil_csr_fifo_shell;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [9:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0]  rdata;
    logic [127:0] csr_data;
    logic [3:0]   csr_w;
    logic [31:0]  ps2pl_data;
    logic         ps2pl_v, ps2pl_yumi;
    logic [31:0]  pl2ps_data;
    logic         pl2ps_v, pl2ps_ready;

    int total = 0;
    int bad   = 0;
    int w1_cnt = 0;

    always #5 aclk = ~aclk;

    zynq_axil_csr_fifo_shell dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .csr_data_o     (csr_data),
        .csr_w_o        (csr_w),
        .ps2pl_data_o   (ps2pl_data),
        .ps2pl_v_o      (ps2pl_v),
        .ps2pl_yumi_i   (ps2pl_yumi),
        .pl2ps_data_i   (pl2ps_data),
        .pl2ps_v_i      (pl2ps_v),
        .pl2ps_ready_o  (pl2ps_ready)
    );

    always @(negedge aclk) if (csr_w[1]) w1_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
        int n;
        @(negedge aclk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        chk("aw_w_accept", {31'b0, awready & wready}, 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge aclk); #1; n++;
        end
        chk("b_latency", n, 0);
        resp = bresp;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [9:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
        int n;
        @(negedge aclk);
        araddr = a; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        chk("ar_accept", {31'b0, arready}, 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge aclk); #1; n++;
        end
        lat = n + 1;
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    int          seen;

    initial begin
        aresetn = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0;
        bready = 0; arvalid = 0; rready = 0;
        ps2pl_yumi = 0; pl2ps_data = '0; pl2ps_v = 0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", {31'b0, awready}, 0);
        chk("rst_arready", {31'b0, arready}, 0);
        chk("rst_bvalid",  {31'b0, bvalid}, 0);
        chk("rst_rvalid",  {31'b0, rvalid}, 0);
        chk("rst_csr0",    csr_data[31:0], 0);
        chk("rst_csr_w",   {28'b0, csr_w}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_ps2pl_v", {31'b0, ps2pl_v}, 0);
        chk("rst_pl2ps_rdy", {31'b0, pl2ps_ready}, 1);
        chk("rst_rdata", rdata, 0);

        axi_wr(10'h004, 32'hDEADBEEF, 4'hF, resp);
        chk("csr1_bresp", {30'b0, resp}, 0);
        chk("csr1_data", csr_data[63:32], 32'hDEADBEEF);
        repeat (2) @(negedge aclk);
        chk("csr1_pulse", w1_cnt, 1);

        axi_wr(10'h000, 32'hFFFFFFFF, 4'hF, resp);
        axi_wr(10'h000, 32'h00000000, 4'b0101, resp);
        chk("csr0_strb", csr_data[31:0], 32'hFF00FF00);
        axi_rd(10'h000, d, resp, lat);
        chk("csr0_rd", d, 32'hFF00FF00);
        chk("csr0_rresp", {30'b0, resp}, 0);
        chk("csr0_lat", lat, 1);

        for (int i = 0; i < 9; i++) begin
            axi_wr(10'h010, 32'h100 + i, 4'hF, resp);
            chk($sformatf("push%0d", i), {30'b0, resp},
                (i < 8) ? 32'd0 : 32'd2);
        end
        axi_rd(10'h014, d, resp, lat);
        chk("free_full", d, 0);
        axi_rd(10'h010, d, resp, lat);
        chk("ps2pl_rd", d, 0);
        chk("ps2pl_rresp", {30'b0, resp}, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            chk($sformatf("yumi_v%0d", i), {31'b0, ps2pl_v}, 1);
            chk($sformatf("yumi_d%0d", i), ps2pl_data, 32'h100 + i);
            ps2pl_yumi = 1'b1;
            @(posedge aclk); #1;
            ps2pl_yumi = 1'b0;
        end
        @(negedge aclk);
        chk("ps2pl_empty", {31'b0, ps2pl_v}, 0);
        axi_rd(10'h014, d, resp, lat);
        chk("free_empty", d, 8);

        axi_rd(10'h018, d, resp, lat);
        chk("pop_empty_d", d, 0);
        chk("pop_empty_r", {30'b0, resp}, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            pl2ps_data = 32'hA0 + i; pl2ps_v = 1'b1;
            #1;
            chk($sformatf("pl_rdy%0d", i), {31'b0, pl2ps_ready}, 1);
            @(posedge aclk); #1;
            pl2ps_v = 1'b0;
        end
        axi_rd(10'h01C, d, resp, lat);
        chk("count3", d, 3);
        for (int i = 0; i < 3; i++) begin
            axi_rd(10'h018, d, resp, lat);
            chk($sformatf("pop_d%0d", i), d, 32'hA0 + i);
            chk($sformatf("pop_r%0d", i), {30'b0, resp}, 0);
        end
        axi_rd(10'h01C, d, resp, lat);
        chk("count0", d, 0);

        @(negedge aclk);
        awaddr = 10'h008; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        araddr = 10'h004; arvalid = 1;
        @(posedge aclk); #1;
        awaddr = 10'h00C;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            chk("stall_bvalid", {31'b0, bvalid}, 1);
            chk("stall_bresp", {30'b0, bresp}, 0);
            chk("stall_rvalid", {31'b0, rvalid}, 1);
            chk("stall_rdata", rdata, 32'hDEADBEEF);
            chk("stall_awready", {31'b0, awready}, 0);
            chk("stall_arready", {31'b0, arready}, 0);
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        @(posedge aclk); #1;
        bready = 0; rready = 0;
        @(negedge aclk);
        chk("stall_bdone", {31'b0, bvalid}, 0);
        chk("stall_rdone", {31'b0, rvalid}, 0);
        chk("csr2_data", csr_data[95:64], 32'h12345678);
        chk("csr3_keep", csr_data[127:96], 0);

        axi_rd(10'h020, d, resp, lat);
        chk("oob_rd_d", d, 0);
        chk("oob_rd_r", {30'b0, resp}, 2);
        axi_wr(10'h014, 32'h55, 4'hF, resp);
        chk("ro_wr_r", {30'b0, resp}, 2);
        axi_wr(10'h018, 32'h66, 4'hF, resp);
        chk("pl2ps_wr_r", {30'b0, resp}, 2);
        axi_wr(10'h010, 32'h77, 4'h7, resp);
        chk("part_push_r", {30'b0, resp}, 2);
        @(negedge aclk);
        chk("part_push_v", {31'b0, ps2pl_v}, 0);
        axi_rd(10'h014, d, resp, lat);
        chk("free_keep", d, 8);
        axi_rd(10'h01C, d, resp, lat);
        chk("count_keep", d, 0);
        chk("csr0_keep", csr_data[31:0], 32'hFF00FF00);
        chk("csr1_keep", csr_data[63:32], 32'hDEADBEEF);

        @(negedge aclk);
        awaddr = 10'h00C; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            if (bvalid) seen++;
        end
        chk("rst_mid_bvalid", seen, 0);
        chk("rst_mid_csr0", csr_data[31:0], 0);
        chk("rst_mid_csr1", csr_data[63:32], 0);
        chk("rst_mid_csr2", csr_data[95:64], 0);
        chk("rst_mid_csr3", csr_data[127:96], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
